idct_mac_sequencer: RTL and testbench

Issue-side controller and result collector for one 26-bit IDCT multiplier PE. It accepts operand pairs through a valid/ready handshake and drives the PE's operand, state, `count0` and reset inputs. It then captures the PE's 32-bit product `P` after a fixed latency, accumulates eight products per output coefficient, and returns eight saturated 32-bit results per 64-pair block through a buffered valid/ready output.

---
 rtl/idct_mac_sequencer_pkg.sv | 46 ++++
 rtl/idct_result_fifo.sv | 60 ++++++
 rtl/idct_mac_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_idct_mac_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_mac_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// idct_mac_sequencer_pkg
// Shared definitions for the IDCT multiplier issue/collect controller:
//   - PE state codes driven on mul_state
//   - block / group geometry (64 pairs per block, 8 pairs per output)
//   - sequencer FSM encoding, latency tag and result record types
//   - issue_state(): PE state code for an accepted pair
// ---------------------------------------------------------------------------
package idct_mac_sequencer_pkg;

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_LOAD  = 3'b001;
  localparam logic [2:0] ST_APX   = 3'b010;
  localparam logic [2:0] ST_ACC   = 3'b011;
  localparam logic [2:0] ST_DRAIN = 3'b100;

  localparam int PAIRS_PER_BLOCK = 64;
  localparam int PAIRS_PER_GROUP = 8;
  localparam int PAIR_W          = $clog2(PAIRS_PER_BLOCK);
  localparam int GRP_W           = $clog2(PAIRS_PER_GROUP);
  localparam int RES_W           = 32;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_PREP  = 2'd1,
    FSM_RUN   = 2'd2,
    FSM_DRAIN = 2'd3
  } fsm_e;

  // Travels alongside a product through the PE latency.
  typedef struct packed {
    logic valid;
    logic first;   // first pair of an 8-pair group: load instead of add
    logic last;    // last pair of a group: push the saturated sum
  } lat_tag_t;

  typedef struct packed {
    logic [GRP_W-1:0] idx;
    logic [RES_W-1:0] data;
  } result_t;

  function automatic logic [2:0] issue_state(input logic apx);
    return apx ? ST_APX : ST_ACC;
  endfunction

endpackage

// File: rtl/idct_result_fifo.sv
// ---------------------------------------------------------------------------
// idct_result_fifo
// Two-entry synchronous FIFO holding finished results (sum + group index).
// Ports:
//   clk, racc        clock, asynchronous active-high reset
//   push, push_data  write side; a push while full is accepted only when a
//                    pop happens in the same cycle
//   pop              read side; ignored while empty
//   head             oldest entry (all-zero after reset)
//   empty, count     occupancy
// ---------------------------------------------------------------------------
module idct_result_fifo
  import idct_mac_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       racc,
  input  logic       push,
  input  result_t    push_data,
  input  logic       pop,
  output result_t    head,
  output logic       empty,
  output logic [1:0] count
);

  result_t    mem_q [2];
  result_t    mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == 2'd0);
  assign count = count_q;

endmodule

// File: rtl/idct_mac_sequencer.sv
// ---------------------------------------------------------------------------
// idct_mac_sequencer
// Issue-side controller and result collector for one IDCT multiplier PE.
// Accepts 64 operand pairs per block, drives the PE, captures its product
// MUL_LAT cycles after issue, sums 8 products per coefficient and returns 8
// saturated 32-bit results through a 2-entry buffered valid/ready output.
// Ports:
//   clk, racc                 clock, asynchronous active-high reset
//   start, apx_mode           block start pulse, approximate-mode select
//   busy, done                block in progress, completion pulse
//   in_valid/in_ready,in_a/b  operand handshake
//   mul_*                     PE operand / control outputs, mul_p product in
//   out_valid/out_ready       result handshake, out_data / out_idx payload
// ---------------------------------------------------------------------------
module idct_mac_sequencer
  import idct_mac_sequencer_pkg::*;
#(
  parameter int DATA_PATH_BITWIDTH = 26,
  parameter int MUL_LAT            = 3,
  parameter int ACC_W              = 35
) (
  input  logic                          clk,
  input  logic                          racc,
  input  logic                          start,
  input  logic                          apx_mode,
  output logic                          busy,
  output logic                          done,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
  input  logic [DATA_PATH_BITWIDTH-12:0] in_b,
  output logic [DATA_PATH_BITWIDTH-1:0] mul_a,
  output logic [DATA_PATH_BITWIDTH-12:0] mul_b,
  output logic [2:0]                    mul_state,
  output logic [8:0]                    mul_count0,
  output logic                          mul_rstP,
  output logic                          mul_rapx,
  output logic                          mul_acc_sel,
  input  logic [31:0]                   mul_p,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_data,
  output logic [2:0]                    out_idx
);

  localparam int OCC_W = $clog2(MUL_LAT + 3) + 1;

  fsm_e                    state_q, state_d;
  logic                    apx_q, apx_d;
  logic [PAIR_W-1:0]       pair_cnt_q, pair_cnt_d;
  logic [GRP_W-1:0]        grp_cnt_q, grp_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  lat_tag_t                tag_q [MUL_LAT];
  lat_tag_t                tag_d [MUL_LAT];

  lat_tag_t                tag_out;
  logic signed [ACC_W-1:0] p_ext;
  logic [ACC_W-32:0]       acc_hi;
  logic [31:0]             sat_val;
  logic                    accept;
  logic                    pipe_busy;
  logic [OCC_W-1:0]        occ;
  logic                    drain_clear;
  logic                    res_push;
  result_t                 res_in, res_head;
  logic                    fifo_empty;
  logic [1:0]              fifo_count;

  // Results that are buffered or already committed to by an in-flight last
  // pair; holding this below 2 guarantees the FIFO can never overflow.
  always_comb begin
    occ       = OCC_W'(fifo_count);
    pipe_busy = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) begin
      occ       = occ + OCC_W'(tag_q[i].last);
      pipe_busy = pipe_busy | tag_q[i].valid;
    end
  end

  assign in_ready    = (state_q == FSM_RUN) && (occ < OCC_W'(2));
  assign accept      = in_valid && in_ready;
  assign drain_clear = !pipe_busy && fifo_empty;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      state_q <= FSM_IDLE;
      apx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      apx_q   <= apx_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    apx_d   = apx_q;
    case (state_q)
      FSM_IDLE: begin
        if (start) begin
          state_d = FSM_PREP;
          apx_d   = apx_mode;
        end
      end
      FSM_PREP:  state_d = FSM_RUN;
      FSM_RUN: begin
        if (accept && (pair_cnt_q == PAIR_W'(PAIRS_PER_BLOCK - 1))) state_d = FSM_DRAIN;
      end
      FSM_DRAIN: begin
        if (drain_clear) state_d = FSM_IDLE;
      end
      default:   state_d = FSM_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mul_rstP  = 1'b0;
    mul_state = ST_IDLE;
    case (state_q)
      FSM_PREP: begin
        busy      = 1'b1;
        mul_rstP  = 1'b1;
        mul_state = ST_LOAD;
      end
      FSM_RUN: begin
        busy      = 1'b1;
        mul_state = accept ? issue_state(apx_q) : ST_LOAD;
      end
      FSM_DRAIN: begin
        busy      = 1'b1;
        mul_state = ST_DRAIN;
        done      = drain_clear;
      end
      default: ;
    endcase
  end

  assign mul_a       = accept ? in_a : '0;
  assign mul_b       = accept ? in_b : '0;
  assign mul_count0  = accept ? 9'(pair_cnt_q) : 9'd0;
  assign mul_rapx    = (state_q != FSM_IDLE) && apx_q;
  assign mul_acc_sel = 1'b0;

  // ---------------- latency tag pipe ----------------
  always_comb begin
    tag_d[0] = '{valid: accept,
                 first: accept && (pair_cnt_q[GRP_W-1:0] == '0),
                 last:  accept && (pair_cnt_q[GRP_W-1:0] == '1)};
    for (int i = 1; i < MUL_LAT; i++) tag_d[i] = tag_q[i-1];
    if (state_q == FSM_PREP) begin
      for (int i = 0; i < MUL_LAT; i++) tag_d[i] = '0;
    end
  end

  assign tag_out = tag_q[MUL_LAT-1];
  assign p_ext   = {{(ACC_W-32){mul_p[31]}}, mul_p};

  // ---------------- accumulate / saturate ----------------
  always_comb begin
    pair_cnt_d = pair_cnt_q;
    grp_cnt_d  = grp_cnt_q;
    acc_d      = acc_q;
    if (state_q == FSM_PREP) begin
      pair_cnt_d = '0;
      grp_cnt_d  = '0;
    end else begin
      if (accept)        pair_cnt_d = pair_cnt_q + PAIR_W'(1);
      if (tag_out.valid) acc_d = tag_out.first ? p_ext : acc_q + p_ext;
      if (res_push)      grp_cnt_d = grp_cnt_q + GRP_W'(1);
    end
  end

  // The sum fits in 32 bits exactly when all bits from 31 upward agree.
  always_comb begin
    acc_hi = acc_d[ACC_W-1:31];
    if ((&acc_hi) || !(|acc_hi)) sat_val = acc_d[31:0];
    else if (acc_d[ACC_W-1])     sat_val = 32'h8000_0000;
    else                         sat_val = 32'h7FFF_FFFF;
  end

  assign res_push = tag_out.valid && tag_out.last;
  assign res_in   = '{idx: grp_cnt_q, data: sat_val};

  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      pair_cnt_q <= '0;
      grp_cnt_q  <= '0;
      acc_q      <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
    end else begin
      pair_cnt_q <= pair_cnt_d;
      grp_cnt_q  <= grp_cnt_d;
      acc_q      <= acc_d;
      for (int i = 0; i < MUL_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  // ---------------- output buffer ----------------
  idct_result_fifo u_fifo (
    .clk       (clk),
    .racc      (racc),
    .push      (res_push),
    .push_data (res_in),
    .pop       (out_ready),
    .head      (res_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = res_head.data;
  assign out_idx   = res_head.idx;

endmodule

// File: tb/tb_idct_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_idct_mac_sequencer
// Directed bench: a behavioural PE returns a*b (or a forced value) MUL_LAT
// cycles after issue. Pair k of a block uses a=k+1, b=(k%8)+2, so group g
// sums to 240 + 352*g.
// ---------------------------------------------------------------------------
module tb_idct_mac_sequencer;
  import idct_mac_sequencer_pkg::*;

  localparam int DW  = 26;
  localparam int BW  = 15;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          racc, start, apx_mode, busy, done, in_valid, in_ready;
  logic [DW-1:0] in_a, mul_a;
  logic [BW-1:0] in_b, mul_b;
  logic [2:0]    mul_state;
  logic [8:0]    mul_count0;
  logic          mul_rstP, mul_rapx, mul_acc_sel;
  logic [31:0]   mul_p;
  logic          out_valid, out_ready;
  logic [31:0]   out_data;
  logic [2:0]    out_idx;

  always #5 clk = ~clk;

  idct_mac_sequencer #(.DATA_PATH_BITWIDTH(DW), .MUL_LAT(LAT), .ACC_W(35)) dut (
    .clk(clk), .racc(racc), .start(start), .apx_mode(apx_mode),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_state(mul_state), .mul_count0(mul_count0), .mul_rstP(mul_rstP),
    .mul_rapx(mul_rapx), .mul_acc_sel(mul_acc_sel), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx)
  );

  // Behavioural PE
  logic        pe_force;
  logic [31:0] pe_force_val;
  logic [31:0] pe_pipe [LAT];

  always @(posedge clk or posedge racc) begin
    if (racc) begin
      for (int i = 0; i < LAT; i++) pe_pipe[i] <= 32'h0;
    end else begin
      if (mul_state == ST_ACC || mul_state == ST_APX)
        pe_pipe[0] <= pe_force ? pe_force_val : (32'(mul_a) * 32'(mul_b));
      else
        pe_pipe[0] <= 32'h0;
      for (int i = 1; i < LAT; i++) pe_pipe[i] <= pe_pipe[i-1];
    end
  end
  assign mul_p = pe_pipe[LAT-1];

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor
  logic        chk_issue = 1'b0;
  logic [2:0]  exp_issue_state = ST_ACC;
  logic        exp_rapx = 1'b0;
  int          issue_cnt = 0;
  int          done_cnt = 0;
  int          blk_pairs = 0;
  logic [31:0] res_data [$];
  logic [2:0]  res_idx [$];

  always @(negedge clk) begin
    if (!racc) begin
      if (out_valid && out_ready) begin
        res_data.push_back(out_data);
        res_idx.push_back(out_idx);
        $display("result idx=%0d data=0x%08h", out_idx, out_data);
      end
      if (done) done_cnt++;
      if (in_valid && in_ready && chk_issue) begin
        check("issue_state", 64'(mul_state), 64'(exp_issue_state));
        check("issue_rapx", 64'(mul_rapx), 64'(exp_rapx));
        check("issue_count0", 64'(mul_count0), 64'(issue_cnt));
        check("issue_a", 64'(mul_a), 64'(in_a));
        issue_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_mul_state", 64'(mul_state), 64'(ST_IDLE));
    check("rst_mul_count0", 64'(mul_count0), 64'd0);
    check("rst_mul_rstP", 64'(mul_rstP), 64'd0);
    check("rst_mul_rapx", 64'(mul_rapx), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_acc_sel", 64'(mul_acc_sel), 64'd0);
  endtask

  task automatic start_block(input logic apx);
    issue_cnt = 0;
    done_cnt  = 0;
    blk_pairs = 0;
    res_data.delete();
    res_idx.delete();
    start = 1'b1;
    apx_mode = apx;
    tick();
    start = 1'b0;
    apx_mode = ~apx;
    @(negedge clk);
    check("prep_busy", 64'(busy), 64'd1);
    check("prep_rstP", 64'(mul_rstP), 64'd1);
    check("prep_state", 64'(mul_state), 64'(ST_LOAD));
    check("prep_in_ready", 64'(in_ready), 64'd0);
    check("prep_rapx", 64'(mul_rapx), 64'(apx));
    tick();
  endtask

  task automatic send_pairs(input int n, input int max_cycles, output int sent, output int first_wait);
    int cyc = 0;
    sent = 0;
    first_wait = -1;
    while (sent < n && cyc < max_cycles) begin
      in_valid = 1'b1;
      in_a = DW'(blk_pairs + sent + 1);
      in_b = BW'(((blk_pairs + sent) % 8) + 2);
      @(negedge clk);
      if (in_ready) begin
        if (first_wait < 0) first_wait = cyc;
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    blk_pairs += sent;
  endtask

  task automatic wait_done(input int budget);
    int   cyc = 0;
    logic seen = 1'b0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      tick();
      cyc++;
    end
    check("done_seen", 64'(seen), 64'd1);
    tick();
    tick();
    check("done_once", 64'(done_cnt), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  // kind 0: exact sums, 1: positive clamp, 2: negative clamp
  task automatic check_results(input int kind);
    logic [31:0] e;
    check("result_count", 64'(res_data.size()), 64'd8);
    for (int g = 0; g < 8 && g < res_data.size(); g++) begin
      if (kind == 0)      e = 32'(240 + 352 * g);
      else if (kind == 1) e = 32'h7FFF_FFFF;
      else                e = 32'h8000_0000;
      check("result_idx", 64'(res_idx[g]), 64'(g));
      check("result_data", 64'(res_data[g]), 64'(e));
    end
  endtask

  task automatic run_full_block(input logic apx, input int kind);
    int sent, fw;
    start_block(apx);
    send_pairs(64, 300, sent, fw);
    check("pairs_sent", 64'(sent), 64'd64);
    check("start_to_ready", 64'(fw), 64'd0);
    wait_done(60);
    check_results(kind);
  endtask

  initial begin
    int sent, fw;
    racc = 1'b1; start = 1'b0; apx_mode = 1'b0;
    in_valid = 1'b1; in_a = DW'(5); in_b = BW'(3);
    out_ready = 1'b1; pe_force = 1'b0; pe_force_val = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    tick();
    racc = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd0);
    check("idle_state", 64'(mul_state), 64'(ST_IDLE));
    check("idle_mul_a", 64'(mul_a), 64'd0);
    tick();
    in_valid = 1'b0;

    // Accurate mode
    chk_issue = 1'b1; exp_issue_state = ST_ACC; exp_rapx = 1'b0;
    run_full_block(1'b0, 0);

    // Approximate mode
    exp_issue_state = ST_APX; exp_rapx = 1'b1;
    run_full_block(1'b1, 0);

    // Saturation at both rails
    exp_issue_state = ST_ACC; exp_rapx = 1'b0;
    pe_force = 1'b1; pe_force_val = 32'h7FFF_FFFF;
    run_full_block(1'b0, 1);
    pe_force_val = 32'h8000_0000;
    run_full_block(1'b0, 2);
    pe_force = 1'b0;

    // Output held off: two results buffered/committed stalls the input
    out_ready = 1'b0;
    start_block(1'b0);
    send_pairs(64, 40, sent, fw);
    check("stall_accepted", 64'(sent), 64'd16);
    @(negedge clk);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    check("stall_no_pop", 64'(res_data.size()), 64'd0);
    tick();
    out_ready = 1'b1;
    send_pairs(48, 300, sent, fw);
    check("stall_rest_sent", 64'(sent), 64'd48);
    wait_done(60);
    check_results(0);

    // Reset in the middle of a block
    start_block(1'b0);
    send_pairs(30, 100, sent, fw);
    in_valid = 1'b1; in_a = DW'(77); in_b = BW'(9);
    racc = 1'b1;
    #1;
    check_reset_outputs();
    tick();
    tick();
    racc = 1'b0;
    in_valid = 1'b0;
    tick();
    run_full_block(1'b0, 0);

    // start pulsed while running is ignored
    start_block(1'b0);
    send_pairs(20, 100, sent, fw);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("mid_start_busy", 64'(busy), 64'd1);
    check("mid_start_rstP", 64'(mul_rstP), 64'd0);
    tick();
    send_pairs(44, 300, sent, fw);
    check("mid_start_sent", 64'(sent), 64'd44);
    wait_done(60);
    check_results(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
